// File: rtl/sume_tuple_pkg.sv
// Tuple widths, metadata field layout and packet-state encoding shared by the
// SUME <-> SDNet tuple alignment blocks.
package sume_tuple_pkg;

  localparam int TUPLE_WIDTH  = 40;
  localparam int DIGEST_WIDTH = 256;

  localparam int PKT_LEN_LSB  = 0;
  localparam int PKT_LEN_MSB  = 15;
  localparam int SRC_PORT_LSB = 16;
  localparam int SRC_PORT_MSB = 23;
  localparam int DST_PORT_LSB = 24;
  localparam int DST_PORT_MSB = 31;
  localparam int SEND_DIG_LSB = 32;
  localparam int SEND_DIG_MSB = 39;

  typedef enum logic {
    PKT_IDLE = 1'b0,
    PKT_BODY = 1'b1
  } pkt_state_e;

  function automatic logic [15:0] meta_pkt_len(input logic [TUPLE_WIDTH-1:0] meta);
    return meta[PKT_LEN_MSB:PKT_LEN_LSB];
  endfunction

endpackage

// File: rtl/tuple_fifo.sv
// Register-based first-word-fall-through queue. Pointers carry an extra MSB so
// full and empty are distinguishable; a push into a full queue is accepted only
// when a pop happens in the same cycle.
module tuple_fifo #(
  parameter int WIDTH = 296,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign level = wr_q - rd_q;

  // Head is forced to zero when empty so stale storage never leaks out.
  assign head  = empty ? '0 : mem[rd_q[AW-1:0]];

  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/sdnet_to_mtpsa.sv
// Attaches the queued {digest, metadata} tuple from SDNet to the first beat of
// the matching egress packet; later beats carry zero tuser.
module sdnet_to_mtpsa #(
  parameter int C_AXIS_DATA_WIDTH = 256,
  parameter int TUPLE_WIDTH       = sume_tuple_pkg::TUPLE_WIDTH,
  parameter int DIGEST_WIDTH      = sume_tuple_pkg::DIGEST_WIDTH,
  parameter int FIFO_DEPTH        = 8,
  localparam int USER_W           = DIGEST_WIDTH + TUPLE_WIDTH,
  localparam int LVL_W            = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                           axis_aclk,
  input  logic                           axis_resetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                           s_axis_tvalid,
  input  logic                           s_axis_tlast,
  output logic                           s_axis_tready,
  input  logic                           tuple_in_valid,
  input  logic [TUPLE_WIDTH-1:0]         tuple_in_data,
  input  logic [DIGEST_WIDTH-1:0]        digest_in_data,
  output logic [C_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                           m_axis_tlast,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [USER_W-1:0]              m_axis_tuser,
  output logic                           tuple_overflow,
  output logic [LVL_W-1:0]               tuple_level
);

  import sume_tuple_pkg::*;

  pkt_state_e        state_q, state_d;
  logic              overflow_q, overflow_d;
  logic              fifo_pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic [USER_W-1:0] fifo_head;

  tuple_fifo #(
    .WIDTH (USER_W),
    .DEPTH (FIFO_DEPTH)
  ) u_tuple_fifo (
    .clk       (axis_aclk),
    .rst_n     (axis_resetn),
    .push      (tuple_in_valid),
    .push_data ({digest_in_data, tuple_in_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (tuple_level)
  );

  assign m_axis_tdata   = s_axis_tdata;
  assign m_axis_tkeep   = s_axis_tkeep;
  assign m_axis_tlast   = s_axis_tlast;
  assign tuple_overflow = overflow_q;

  always_comb begin
    state_d       = state_q;
    fifo_pop      = 1'b0;
    m_axis_tvalid = 1'b0;
    s_axis_tready = 1'b0;
    m_axis_tuser  = '0;
    case (state_q)
      PKT_IDLE: begin
        // A first beat waits until its tuple is at the head of the queue.
        m_axis_tvalid = s_axis_tvalid & ~fifo_empty;
        s_axis_tready = m_axis_tready & ~fifo_empty;
        m_axis_tuser  = fifo_head;
        fifo_pop      = s_axis_tvalid & m_axis_tready & ~fifo_empty;
        if (fifo_pop && !s_axis_tlast) state_d = PKT_BODY;
      end
      PKT_BODY: begin
        m_axis_tvalid = s_axis_tvalid;
        s_axis_tready = m_axis_tready;
        if (s_axis_tvalid && m_axis_tready && s_axis_tlast) state_d = PKT_IDLE;
      end
      default: state_d = PKT_IDLE;
    endcase
    overflow_d = overflow_q | (tuple_in_valid & fifo_full & ~fifo_pop);
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q    <= PKT_IDLE;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_sdnet_to_mtpsa.sv
// Scoreboard bench for sdnet_to_mtpsa: expected beats are queued as the source
// drives them and compared when the output handshakes.
module tb_sdnet_to_mtpsa;

  localparam int DW = 256;
  localparam int KW = DW / 8;
  localparam int UW = 296;
  localparam int LW = 4;

  typedef logic [UW-1:0] v_t;
  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [UW-1:0] user;
  } beat_t;

  logic          clk = 1'b0;
  logic          axis_resetn;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          s_tvalid, s_tlast, s_tready;
  logic          tuple_in_valid;
  logic [39:0]   tuple_in_data;
  logic [255:0]  digest_in_data;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tlast, m_tvalid, m_tready;
  logic [UW-1:0] m_tuser;
  logic          tuple_overflow;
  logic [LW-1:0] tuple_level;

  int n_vec = 0;
  int n_err = 0;
  int pkt_no = 0;
  bit mon_en = 0;
  bit bp_en = 0;

  v_t    tq[$];
  beat_t beat_q[$];

  always #5 clk = ~clk;

  sdnet_to_mtpsa dut (
    .axis_aclk      (clk),
    .axis_resetn    (axis_resetn),
    .s_axis_tdata   (s_tdata),
    .s_axis_tkeep   (s_tkeep),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tlast   (s_tlast),
    .s_axis_tready  (s_tready),
    .tuple_in_valid (tuple_in_valid),
    .tuple_in_data  (tuple_in_data),
    .digest_in_data (digest_in_data),
    .m_axis_tdata   (m_tdata),
    .m_axis_tkeep   (m_tkeep),
    .m_axis_tlast   (m_tlast),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tready  (m_tready),
    .m_axis_tuser   (m_tuser),
    .tuple_overflow (tuple_overflow),
    .tuple_level    (tuple_level)
  );

  task automatic chk(input string tag, input v_t obs, input v_t exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Output monitor: handshake pairing, scoreboard compare, payload hold under stall.
  logic          prev_stall = 1'b0;
  logic [UW-1:0] prev_user;
  logic [DW-1:0] prev_data;
  always @(negedge clk) begin
    beat_t e;
    if (!mon_en) begin
      prev_stall = 1'b0;
    end else begin
      chk("xfer", v_t'(m_tvalid & m_tready), v_t'(s_tvalid & s_tready));
      if (prev_stall && m_tvalid) begin
        chk("hold_user", v_t'(m_tuser), v_t'(prev_user));
        chk("hold_data", v_t'(m_tdata), v_t'(prev_data));
      end
      if (m_tvalid && m_tready) begin
        if (beat_q.size() == 0) begin
          chk("extra_beat", v_t'(beat_q.size()), v_t'(1));
        end else begin
          e = beat_q.pop_front();
          chk("tdata", v_t'(m_tdata), v_t'(e.data));
          chk("tlast", v_t'(m_tlast), v_t'(e.last));
          chk("tuser", v_t'(m_tuser), e.user);
          chk("tkeep", v_t'(m_tkeep), v_t'({KW{1'b1}}));
        end
      end
      prev_stall = m_tvalid & ~m_tready;
      prev_user  = m_tuser;
      prev_data  = m_tdata;
    end
  end

  // Downstream backpressure source.
  always @(posedge clk) begin
    #1;
    m_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic drive_tuple(input v_t t);
    @(posedge clk); #1;
    tuple_in_valid = 1'b1;
    {digest_in_data, tuple_in_data} = t;
    @(posedge clk); #1;
    tuple_in_valid = 1'b0;
  endtask

  task automatic push_tuple(input v_t t);
    tq.push_back(t);
    drive_tuple(t);
  endtask

  task automatic push_burst(input int n, input int keep);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      tuple_in_valid = 1'b1;
      digest_in_data = 256'(i + 32'h100);
      tuple_in_data  = 40'(i);
      if (i < keep) tq.push_back({digest_in_data, tuple_in_data});
      @(posedge clk); #1;
    end
    tuple_in_valid = 1'b0;
  endtask

  task automatic send_pkt(input int n, output int waits);
    beat_t         e;
    logic [UW-1:0] u;
    int            cnt;
    waits = 0;
    @(posedge clk); #1;
    u = (tq.size() > 0) ? tq.pop_front() : '0;
    for (int b = 0; b < n; b++) begin
      s_tdata  = {8{$urandom()}};
      s_tlast  = (b == n - 1);
      s_tvalid = 1'b1;
      e.data = s_tdata;
      e.last = s_tlast;
      e.user = (b == 0) ? u : '0;
      beat_q.push_back(e);
      cnt = 0;
      @(negedge clk);
      while (!s_tready && cnt < 200) begin
        cnt++;
        @(negedge clk);
      end
      if (b == 0) waits = cnt;
      if (!s_tready) chk("timeout", v_t'(s_tready), v_t'(1));
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    $display("pkt %0d: %0d beats, first-beat wait %0d", pkt_no, n, waits);
    pkt_no++;
  endtask

  task automatic do_reset();
    mon_en = 0;
    axis_resetn = 1'b0;
    s_tvalid = 1'b0;
    tuple_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    axis_resetn = 1'b1;
    tq.delete();
    beat_q.delete();
    mon_en = 1;
  endtask

  initial begin
    int w;
    v_t t;
    axis_resetn = 1'b0;
    s_tdata = '0;
    s_tkeep = '1;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    tuple_in_valid = 1'b0;
    tuple_in_data = '0;
    digest_in_data = '0;
    m_tready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_tvalid", v_t'(m_tvalid), v_t'(0));
    chk("rst_tready", v_t'(s_tready), v_t'(0));
    chk("rst_tuser", v_t'(m_tuser), v_t'(0));
    chk("rst_level", v_t'(tuple_level), v_t'(0));
    chk("rst_ovf", v_t'(tuple_overflow), v_t'(0));
    axis_resetn = 1'b1;
    mon_en = 1;

    // Tuple ahead of a 2-beat packet: zero-latency release
    push_tuple({256'hAB, 40'h0101040040});
    repeat (2) @(posedge clk);
    send_pkt(2, w);
    chk("t1_wait", v_t'(w), v_t'(0));
    @(negedge clk);
    chk("t1_level", v_t'(tuple_level), v_t'(0));

    // First beat ahead of its tuple: stall, release the cycle after push
    t = {256'hC0DE, 40'h0002030004};
    tq.push_back(t);
    fork
      send_pkt(1, w);
      begin
        repeat (5) begin
          @(negedge clk);
          chk("t2_stall", v_t'(s_tready), v_t'(0));
        end
        drive_tuple(t);
        @(negedge clk);
        chk("t2_release", v_t'(s_tready), v_t'(1));
      end
    join
    @(negedge clk);
    chk("t2_level", v_t'(tuple_level), v_t'(0));

    // Nine back-to-back tuples into an 8-deep queue
    push_burst(9, 8);
    @(negedge clk);
    chk("t3_level", v_t'(tuple_level), v_t'(8));
    chk("t3_ovf", v_t'(tuple_overflow), v_t'(1));
    for (int i = 0; i < 8; i++) send_pkt(1, w);
    @(negedge clk);
    chk("t3_drain", v_t'(tuple_level), v_t'(0));
    chk("t3_sticky", v_t'(tuple_overflow), v_t'(1));

    // Push while full coincides with a first-beat pop
    do_reset();
    chk("t5_ovf_clr", v_t'(tuple_overflow), v_t'(0));
    push_burst(8, 8);
    fork
      send_pkt(1, w);
      push_tuple({256'h5A5A, 40'h00FF00FF00});
    join
    @(negedge clk);
    chk("t5_level", v_t'(tuple_level), v_t'(8));
    chk("t5_ovf", v_t'(tuple_overflow), v_t'(0));
    for (int i = 0; i < 8; i++) send_pkt(1, w);
    @(negedge clk);
    chk("t5_drain", v_t'(tuple_level), v_t'(0));

    // Random backpressure over 100 packets of 1..6 beats
    bp_en = 1;
    for (int p = 0; p < 100; p++) begin
      int n;
      n = int'($urandom_range(1, 6));
      t = {{8{$urandom()}}, 8'h00, $urandom()};
      if ($urandom_range(0, 1) == 1) begin
        fork
          push_tuple(t);
          send_pkt(n, w);
        join
      end else begin
        push_tuple(t);
        send_pkt(n, w);
      end
    end
    bp_en = 0;
    repeat (3) @(negedge clk);
    chk("t4_sb_empty", v_t'(beat_q.size()), v_t'(0));
    chk("t4_level", v_t'(tuple_level), v_t'(0));

    // Reset during beat 2 of a 4-beat packet with 3 tuples queued
    do_reset();
    for (int i = 0; i < 3; i++) drive_tuple({256'(i + 7), 40'(i)});
    mon_en = 0;
    @(posedge clk); #1;
    s_tdata = {8{$urandom()}};
    s_tlast = 1'b0;
    s_tvalid = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      s_tdata = {8{$urandom()}};
    end
    #2;
    axis_resetn = 1'b0;
    #1;
    chk("t6_tvalid", v_t'(m_tvalid), v_t'(0));
    chk("t6_tready", v_t'(s_tready), v_t'(0));
    chk("t6_tuser", v_t'(m_tuser), v_t'(0));
    chk("t6_level", v_t'(tuple_level), v_t'(0));
    chk("t6_ovf", v_t'(tuple_overflow), v_t'(0));
    s_tvalid = 1'b0;
    @(negedge clk);
    axis_resetn = 1'b1;
    tq.delete();
    beat_q.delete();
    mon_en = 1;
    push_tuple({256'hFEED, 40'h0101020030});
    send_pkt(2, w);
    repeat (2) @(negedge clk);
    chk("t6_sb_empty", v_t'(beat_q.size()), v_t'(0));
    chk("t6_level_end", v_t'(tuple_level), v_t'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
